// File: rtl/cam_grey_packer.sv
// rtl/cam_grey_packer.sv - RGB565 to N-bit grey converter, decimator and BRAM word packer
module cam_grey_packer #(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int PIX_PER_WORD = 6,
    parameter int GREY_BITS    = 8,
    parameter int DECIMATE     = 1,
    parameter int MODE         = 0,
    localparam int OW     = FRAME_WIDTH / DECIMATE,
    localparam int OH     = FRAME_HEIGHT / DECIMATE,
    localparam int WORDS  = (OW * OH + PIX_PER_WORD - 1) / PIX_PER_WORD,
    localparam int ADDR_W = $clog2(WORDS),
    localparam int DATA_W = PIX_PER_WORD * GREY_BITS
) (
    input  logic              clk_pixel,
    input  logic              rst_in,
    input  logic [15:0]       pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              valid_in,
    input  logic              frame_done_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              wea_out,
    output logic              frame_done_out,
    output logic              oor_out
);

    localparam int DSH    = (DECIMATE == 4) ? 2 : (DECIMATE == 2) ? 1 : 0;
    localparam int IDX_W  = $clog2(OW * OH) + 1;
    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [7:0]  r8, g8, b8;
    logic        in_range, dec_ok;

    logic        s1_valid, s1_fd, s1_oor, s1_keep;
    logic [10:0] s1_hd;
    logic [9:0]  s1_vd;
    logic [15:0] s1_pr, s1_pg, s1_pb;
    logic [7:0]  s1_g8;

    logic             s2_valid, s2_fd, s2_oor;
    logic [15:0]      s2_sum;
    logic [7:0]       s2_g8;
    logic [IDX_W-1:0] s2_idx;

    logic                 s3_valid, s3_fd;
    logic [ADDR_W-1:0]    s3_word;
    logic [LANE_W-1:0]    s3_lane;
    logic [GREY_BITS-1:0] s3_grey;

    logic [IDX_W-1:0] quo, rem;
    logic [7:0]       y8;

    logic [DATA_W-1:0] buf_data, n_buf_data, pend_data, n_pend_data, e_data;
    logic [ADDR_W-1:0] buf_word, n_buf_word, pend_word, n_pend_word, e_addr;
    logic              buf_valid, n_buf_valid, pend_valid, n_pend_valid;
    logic              flush_req, n_flush, done_req, n_done_req, emit, done_now;

    always_comb begin
        r8       = {pixel_in[15:11], 3'b000};
        g8       = {pixel_in[10:5], 2'b00};
        b8       = {pixel_in[4:0], 3'b000};
        in_range = (hcount_in < 11'(FRAME_WIDTH)) && (vcount_in < 10'(FRAME_HEIGHT));
        dec_ok   = ((hcount_in & 11'(DECIMATE - 1)) == 11'd0) &&
                   ((vcount_in & 10'(DECIMATE - 1)) == 10'd0);
        quo      = s2_idx / IDX_W'(PIX_PER_WORD);
        rem      = s2_idx % IDX_W'(PIX_PER_WORD);
        y8       = (MODE == 1) ? s2_g8 : s2_sum[15:8];
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_in) begin
            s1_valid <= 1'b0; s1_fd <= 1'b0; s1_oor <= 1'b0; s1_keep <= 1'b0;
            s1_hd <= '0; s1_vd <= '0; s1_pr <= '0; s1_pg <= '0; s1_pb <= '0; s1_g8 <= '0;
            s2_valid <= 1'b0; s2_fd <= 1'b0; s2_oor <= 1'b0;
            s2_sum <= '0; s2_g8 <= '0; s2_idx <= '0;
            s3_valid <= 1'b0; s3_fd <= 1'b0; s3_word <= '0; s3_lane <= '0; s3_grey <= '0;
            oor_out <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            s1_fd    <= frame_done_in;
            s1_oor   <= !in_range;
            s1_keep  <= in_range && dec_ok;
            s1_hd    <= hcount_in >> DSH;
            s1_vd    <= vcount_in >> DSH;
            s1_pr    <= 16'(r8) * 16'd77;
            s1_pg    <= 16'(g8) * 16'd150;
            s1_pb    <= 16'(b8) * 16'd29;
            s1_g8    <= g8;

            s2_valid <= s1_valid && s1_keep;
            s2_oor   <= s1_valid && s1_oor;
            s2_fd    <= s1_fd;
            s2_sum   <= s1_pr + s1_pg + s1_pb;
            s2_g8    <= s1_g8;
            s2_idx   <= IDX_W'(s1_vd) * IDX_W'(OW) + IDX_W'(s1_hd);

            s3_valid <= s2_valid;
            s3_fd    <= s2_fd;
            s3_word  <= quo[ADDR_W-1:0];
            s3_lane  <= rem[LANE_W-1:0];
            s3_grey  <= y8[7 -: GREY_BITS];
            oor_out  <= oor_out | s2_oor;
        end
    end

    // One BRAM write per cycle: a full word that collides with a discontinuity
    // flush is parked in the pending slot; a frame flush waits for a free cycle.
    always_comb begin
        n_buf_data   = buf_data;
        n_buf_word   = buf_word;
        n_buf_valid  = buf_valid;
        n_pend_valid = 1'b0;
        n_pend_word  = pend_word;
        n_pend_data  = pend_data;
        n_flush      = 1'b0;
        n_done_req   = 1'b0;
        done_now     = done_req;
        emit         = 1'b0;
        e_addr       = addr_out;
        e_data       = data_out;

        if (pend_valid) begin
            emit   = 1'b1;
            e_addr = pend_word;
            e_data = pend_data;
        end

        if (s3_valid) begin
            if (buf_valid && (s3_word != buf_word)) begin
                emit       = 1'b1;
                e_addr     = buf_word;
                e_data     = buf_data;
                n_buf_data = '0;
            end else if (!buf_valid) begin
                n_buf_data = '0;
            end
            n_buf_word  = s3_word;
            n_buf_valid = 1'b1;
            for (int k = 0; k < PIX_PER_WORD; k++) begin
                if (s3_lane == LANE_W'(k))
                    n_buf_data[DATA_W-1-k*GREY_BITS -: GREY_BITS] = s3_grey;
            end
            if (s3_lane == LANE_W'(PIX_PER_WORD - 1)) begin
                if (emit) begin
                    n_pend_valid = 1'b1;
                    n_pend_word  = s3_word;
                    n_pend_data  = n_buf_data;
                end else begin
                    emit   = 1'b1;
                    e_addr = s3_word;
                    e_data = n_buf_data;
                end
                n_buf_valid = 1'b0;
                n_buf_data  = '0;
            end
        end

        if (s3_fd || flush_req) begin
            if (n_buf_valid) begin
                if (!emit) begin
                    emit        = 1'b1;
                    e_addr      = n_buf_word;
                    e_data      = n_buf_data;
                    n_buf_valid = 1'b0;
                    n_buf_data  = '0;
                    n_done_req  = 1'b1;
                end else begin
                    n_flush = 1'b1;
                end
            end else if (n_pend_valid) begin
                n_flush = 1'b1;
            end else if (emit) begin
                n_done_req = 1'b1;
            end else begin
                done_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_in) begin
            buf_data       <= '0;
            buf_word       <= '0;
            buf_valid      <= 1'b0;
            pend_valid     <= 1'b0;
            pend_word      <= '0;
            pend_data      <= '0;
            flush_req      <= 1'b0;
            done_req       <= 1'b0;
            addr_out       <= '0;
            data_out       <= '0;
            wea_out        <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            buf_data       <= n_buf_data;
            buf_word       <= n_buf_word;
            buf_valid      <= n_buf_valid;
            pend_valid     <= n_pend_valid;
            pend_word      <= n_pend_word;
            pend_data      <= n_pend_data;
            flush_req      <= n_flush;
            done_req       <= n_done_req;
            wea_out        <= emit;
            frame_done_out <= done_now;
            if (emit) begin
                addr_out <= e_addr;
                data_out <= e_data;
            end
        end
    end

endmodule

// File: tb/tb_cam_grey_packer.sv
// tb/tb_cam_grey_packer.sv - self-checking bench for cam_grey_packer
module tb_cam_grey_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pixel = '0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        valid = 1'b0;
    logic        fdone = 1'b0;

    logic [13:0] addr_a;
    logic [47:0] data_a;
    logic        wea_a, fdo_a, oor_a;
    logic [11:0] addr_b;
    logic [47:0] data_b;
    logic        wea_b, fdo_b, oor_b;
    logic [16:0] addr_c;
    logic [3:0]  data_c;
    logic        wea_c, fdo_c, oor_c;

    always #5 clk = ~clk;

    cam_grey_packer dut_a (
        .clk_pixel(clk), .rst_in(rst), .pixel_in(pixel), .hcount_in(hcount),
        .vcount_in(vcount), .valid_in(valid), .frame_done_in(fdone),
        .addr_out(addr_a), .data_out(data_a), .wea_out(wea_a),
        .frame_done_out(fdo_a), .oor_out(oor_a));

    cam_grey_packer #(.DECIMATE(2)) dut_b (
        .clk_pixel(clk), .rst_in(rst), .pixel_in(pixel), .hcount_in(hcount),
        .vcount_in(vcount), .valid_in(valid), .frame_done_in(fdone),
        .addr_out(addr_b), .data_out(data_b), .wea_out(wea_b),
        .frame_done_out(fdo_b), .oor_out(oor_b));

    cam_grey_packer #(.MODE(1), .GREY_BITS(4), .PIX_PER_WORD(1)) dut_c (
        .clk_pixel(clk), .rst_in(rst), .pixel_in(pixel), .hcount_in(hcount),
        .vcount_in(vcount), .valid_in(valid), .frame_done_in(fdone),
        .addr_out(addr_c), .data_out(data_c), .wea_out(wea_c),
        .frame_done_out(fdo_c), .oor_out(oor_c));

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int last_vcyc, last_fcyc;

    int          qa_addr[$];
    logic [47:0] qa_data[$];
    int          qa_cyc[$];
    int          qf_cyc[$];
    int          exp_addr[$];
    logic [47:0] exp_data[$];

    int          nb = 0, nc = 0;
    logic [11:0] lb_addr = '0;
    logic [47:0] lb_data = '0;
    logic [16:0] lc_addr = '0;
    logic [3:0]  lc_data = '0;

    // Reference packer for the default configuration: a word-sized list of lanes.
    bit m_have = 1'b0;
    int m_word = 0;
    int m_lane[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wea_a) begin
            qa_addr.push_back(int'(addr_a));
            qa_data.push_back(data_a);
            qa_cyc.push_back(cyc);
        end
        if (fdo_a) qf_cyc.push_back(cyc);
        if (wea_b) begin
            nb      <= nb + 1;
            lb_addr <= addr_b;
            lb_data <= data_b;
        end
        if (wea_c) begin
            nc      <= nc + 1;
            lc_addr <= addr_c;
            lc_data <= data_c;
        end
    end

    function automatic int grey_a(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]) * 8;
        g = int'(p[10:5]) * 4;
        b = int'(p[4:0]) * 8;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic void m_emit();
        logic [47:0] d;
        d = '0;
        for (int k = 0; k < 6; k++) begin
            d = d | (48'(m_lane[k]) << ((5 - k) * 8));
            m_lane[k] = 0;
        end
        exp_addr.push_back(m_word);
        exp_data.push_back(d);
        m_have = 1'b0;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < 6; k++) m_lane[k] = 0;
        m_have = 1'b0;
    endfunction

    function automatic void m_pix(input int h, input int v, input logic [15:0] p);
        int idx;
        if (h < 320 && v < 240) begin
            idx = v * 320 + h;
            if (m_have && (idx / 6) != m_word) m_emit();
            m_have = 1'b1;
            m_word = idx / 6;
            m_lane[idx % 6] = grey_a(p);
            if (idx % 6 == 5) m_emit();
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic px(input int h, input int v, input logic [15:0] p);
        hcount    = 11'(h);
        vcount    = 10'(v);
        pixel     = p;
        valid     = 1'b1;
        last_vcyc = cyc;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        m_pix(h, v, p);
    endtask

    task automatic frame_end();
        fdone     = 1'b1;
        last_fcyc = cyc;
        @(posedge clk); #1;
        fdone = 1'b0;
        @(posedge clk); #1;
        if (m_have) m_emit();
    endtask

    task automatic clr();
        qa_addr.delete(); qa_data.delete(); qa_cyc.delete(); qf_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic cmp_a(input string tag);
        chk({tag, ".nwr"}, 64'(qa_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < qa_addr.size() && i < exp_addr.size(); i++) begin
            chk({tag, ".addr"}, 64'(qa_addr[i]), 64'(exp_addr[i]));
            chk({tag, ".data"}, 64'(qa_data[i]), 64'(exp_data[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p0, p1, p2, p3;
        logic [7:0]  g0, g1, g2, g3;
        int          v12, nb0, nc0, h, v;

        m_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.wea", 64'(wea_a), 64'd0);
        chk("rst.fdo", 64'(fdo_a), 64'd0);
        chk("rst.oor", 64'(oor_a), 64'd0);
        chk("rst.addr", 64'(addr_a), 64'd0);
        chk("rst.data", 64'(data_a), 64'd0);
        chk("rst.oor_b", 64'(oor_b), 64'd0);
        chk("rst.wea_c", 64'(wea_c), 64'd0);

        // full-scale white word
        clr();
        for (int i = 0; i < 6; i++) px(i, 0, 16'hFFFF);
        idle(6);
        chk("t1.nwr", 64'(qa_addr.size()), 64'd1);
        chk("t1.addr", 64'(qa_addr[0]), 64'd0);
        chk("t1.data", 64'(qa_data[0]), 64'hFAFAFAFAFAFA);
        chk("t1.lat", 64'(qa_cyc[0] - last_vcyc), 64'd4);
        cmp_a("t1");

        // discontinuity flush, then frame-end flush of word 2
        clr();
        p0 = 16'($urandom); p1 = 16'($urandom); p2 = 16'($urandom); p3 = 16'($urandom);
        g0 = 8'(grey_a(p0)); g1 = 8'(grey_a(p1)); g2 = 8'(grey_a(p2)); g3 = 8'(grey_a(p3));
        px(0, 0, p0); px(1, 0, p1); px(2, 0, p2); px(12, 0, p3);
        v12 = last_vcyc;
        idle(6);
        chk("t2.nwr", 64'(qa_addr.size()), 64'd1);
        chk("t2.addr", 64'(qa_addr[0]), 64'd0);
        chk("t2.data", 64'(qa_data[0]), 64'({g0, g1, g2, 24'd0}));
        chk("t2.when", 64'(qa_cyc[0] - v12), 64'd4);
        frame_end();
        idle(6);
        chk("t2.nwr2", 64'(qa_addr.size()), 64'd2);
        chk("t2.addr2", 64'(qa_addr[1]), 64'd2);
        chk("t2.data2", 64'(qa_data[1]), 64'({g3, 40'd0}));
        chk("t2.nfd", 64'(qf_cyc.size()), 64'd1);
        chk("t2.fdlat", 64'(qf_cyc[0] - qa_cyc[1]), 64'd1);
        cmp_a("t2");

        // word spanning a line boundary
        clr();
        px(318, 0, 16'($urandom)); px(319, 0, 16'($urandom));
        for (int i = 0; i < 4; i++) px(i, 1, 16'($urandom));
        idle(6);
        chk("t3.nwr", 64'(qa_addr.size()), 64'd1);
        chk("t3.addr", 64'(qa_addr[0]), 64'd53);
        cmp_a("t3");
        frame_end();
        idle(6);
        chk("t3.nfd", 64'(qf_cyc.size()), 64'd1);
        chk("t3.fdempty", 64'(qf_cyc[0] - last_fcyc), 64'd4);
        chk("t3.nwr2", 64'(qa_addr.size()), 64'd1);

        // partial word at frame end
        clr();
        px(6, 0, p0); px(7, 0, p1);
        frame_end();
        idle(6);
        chk("t4.nwr", 64'(qa_addr.size()), 64'd1);
        chk("t4.addr", 64'(qa_addr[0]), 64'd1);
        chk("t4.data", 64'(qa_data[0]), 64'({g0, g1, 32'd0}));
        chk("t4.nfd", 64'(qf_cyc.size()), 64'd1);
        chk("t4.fdlat", 64'(qf_cyc[0] - qa_cyc[0]), 64'd1);

        // decimate-by-2 instance, then out-of-range pixel
        clr();
        nb0 = nb;
        px(3, 2, p2); px(4, 2, p3);
        frame_end();
        idle(6);
        chk("t5.nwr_b", 64'(nb - nb0), 64'd1);
        chk("t5.addr_b", 64'(lb_addr), 64'd27);
        chk("t5.data_b", 64'(lb_data), 64'({g3, 40'd0}));
        chk("t5.oor_b0", 64'(oor_b), 64'd0);
        cmp_a("t5");
        clr();
        nb0 = nb;
        px(320, 0, 16'($urandom));
        idle(6);
        chk("t5.oor_nwr_b", 64'(nb - nb0), 64'd0);
        chk("t5.oor_b", 64'(oor_b), 64'd1);
        chk("t5.oor_a", 64'(oor_a), 64'd1);
        idle(20);
        chk("t5.oor_sticky", 64'(oor_b), 64'd1);
        cmp_a("t5oor");

        // random raster fragments against the reference packer
        clr();
        for (v = 20; v < 23; v++) begin
            h = $urandom_range(0, 3);
            while (h < 330) begin
                px(h, v, 16'($urandom));
                h += $urandom_range(1, 4);
                if ($urandom_range(0, 9) == 0) h += 20;
            end
        end
        frame_end();
        idle(8);
        cmp_a("rnd");
        chk("rnd.nfd", 64'(qf_cyc.size()), 64'd1);

        // green-only, 4-bit, one sample per word
        nc0 = nc;
        px(5, 3, 16'h07E0);
        idle(6);
        chk("t6.nwr_c", 64'(nc - nc0), 64'd1);
        chk("t6.addr_c", 64'(lc_addr), 64'd965);
        chk("t6.data_c", 64'(lc_data), 64'hF);
        p0 = 16'($urandom);
        h  = $urandom_range(0, 319);
        v  = $urandom_range(0, 239);
        px(h, v, p0);
        idle(6);
        chk("t6.raddr_c", 64'(lc_addr), 64'(v * 320 + h));
        chk("t6.rdata_c", 64'(lc_data), 64'(p0[10:7]));
        frame_end();
        idle(6);

        // reset discards a partial word
        clr();
        px(0, 0, 16'($urandom)); px(1, 0, 16'($urandom)); px(2, 0, 16'($urandom));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        m_clear();
        idle(6);
        chk("t6.rst_nwr", 64'(qa_addr.size()), 64'd0);
        chk("t6.rst_oor", 64'(oor_a), 64'd0);
        p1 = 16'($urandom); p2 = 16'($urandom); p3 = 16'($urandom);
        px(3, 0, p1); px(4, 0, p2); px(5, 0, p3);
        frame_end();
        idle(6);
        chk("t6.nwr", 64'(qa_addr.size()), 64'd1);
        chk("t6.data", 64'(qa_data[0]),
            64'({24'd0, 8'(grey_a(p1)), 8'(grey_a(p2)), 8'(grey_a(p3))}));
        chk("t6.fdempty", 64'(qf_cyc[0] - last_fcyc), 64'd4);
        cmp_a("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_grey_packer.md
Name: cam_grey_packer

Overview:
- Parametrised successor to the camera-top greyscale write path.
- Takes recovered RGB565 camera pixels with their hcount/vcount and a valid strobe.
- Converts each pixel to N-bit grey (full luma or green-only). Optionally decimates by 1/2/4.
- Packs PIX_PER_WORD grey samples per BRAM word and issues address/data/write-enable.
- Partial words are flushed on address discontinuity and at frame end, so no sample is lost or mis-addressed.

Parameters:
- FRAME_WIDTH, 320, source active width in pixels.
- FRAME_HEIGHT, 240, source active height in lines.
- PIX_PER_WORD, 6, grey samples packed per BRAM word (1..8).
- GREY_BITS, 8, bits per grey sample (1..8); top bits of the 8-bit result are kept.
- DECIMATE, 1, spatial decimation factor: 1, 2 or 4.
- MODE, 0, 0 = luma Y=(77R+150G+29B)>>8; 1 = green channel only.
- Derived (localparam):
  - OW = FRAME_WIDTH/DECIMATE
  - OH = FRAME_HEIGHT/DECIMATE
  - WORDS = ceil(OW*OH/PIX_PER_WORD)
  - ADDR_W = $clog2(WORDS)
  - DATA_W = PIX_PER_WORD*GREY_BITS

Ports:
- clk_pixel  in  1  system pixel clock, 74.25 MHz.
- rst_in  in  1  synchronous active-high reset.
- pixel_in  in  16  RGB565 pixel.
- hcount_in  in  11  pixel column.
- vcount_in  in  10  pixel row.
- valid_in  in  1  single-cycle pixel strobe; never asserted on two consecutive cycles.
- frame_done_in  in  1  single-cycle end-of-frame strobe.
- addr_out  out  ADDR_W  BRAM word address.
- data_out  out  DATA_W  packed word; oldest sample in the most-significant lane.
- wea_out  out  1  single-cycle write enable.
- frame_done_out  out  1  single-cycle pulse after the frame's final write.
- oor_out  out  1  sticky flag: an out-of-range pixel was seen since reset.

Behaviour:
- Reset: all outputs 0, pack buffer empty, pending-write flag clear, pipelines cleared. A partial word held at reset is discarded; no write is issued.
- Channel expansion: R={r5,3'b0}, G={g6,2'b0}, B={b5,3'b0}.
  - Luma uses 16-bit products and sum, then >>8 to 8 bits.
  - Grey sample = result[7:8-GREY_BITS].
- Stage pipeline, 3 cycles: expand/multiply, sum, select/truncate. Index computation and valid/frame_done travel alongside, so ordering is preserved.
- Stage-3 filtering:
  - Drop the pixel if hcount_in>=FRAME_WIDTH or vcount_in>=FRAME_HEIGHT; set oor_out.
  - Drop if DECIMATE>1 and (h%DECIMATE!=0 or v%DECIMATE!=0).
- Index and placement:
  - idx = (v/DECIMATE)*OW + h/DECIMATE
  - word = idx/PIX_PER_WORD, lane = idx%PIX_PER_WORD
  - Divide/modulo by power-of-two DECIMATE are shifts; /PIX_PER_WORD is a constant divide, pipelined inside the 3 stages.
- Pack cycle (stage 3 + 1):
  - If buffer non-empty and word != buffered word: emit the buffer (unwritten lanes = 0) and start a new buffer with this sample.
  - Write the sample into its lane.
  - If lane==PIX_PER_WORD-1: emit the buffer and clear it.
  - If both emits fall in the same cycle: emit the old buffer now, and emit the new full word on the next cycle (pending flag). The input spacing rule guarantees no collision.
- Emit: register addr_out/data_out and pulse wea_out for 1 cycle.
  - Latency from valid_in of a word-completing sample to wea_out = 4 cycles.
  - addr_out/data_out hold their value until the next emit.
- Frame end, after the 3-cycle delay:
  - Buffer non-empty: flush it on the next free cycle, then pulse frame_done_out 1 cycle after that wea_out.
  - Buffer empty: pulse frame_done_out 1 cycle after the delayed strobe.
  - In all cases the buffer is empty after frame end.
- A sample and delayed frame_done_in in the same cycle: the sample is placed first, then the flush follows.
- Lane mapping: lane k occupies data_out[DATA_W-1-k*GREY_BITS -: GREY_BITS].
- PIX_PER_WORD=1: every accepted sample writes; no pending buffer ever exists.

Test Plan:
1. Defaults, pixel_in=16'hFFFF, h=0..5, v=0, valid every 2 cycles -> one wea_out, 4 cycles after the 6th valid; addr_out=0; data_out=48'hFAFAFAFAFAFA.
2. Defaults, pixels at h=0,1,2 then h=12, v=0 -> write addr 0, data {Y0,Y1,Y2,0,0,0} on the h=12 pack cycle; sample 12 is buffered in word 2, lane 0.
3. Defaults, h=318,319 (v=0) then h=0,1,2,3 (v=1) -> a single write at addr 53 with six samples; no discontinuity flush.
4. Defaults, h=6,7 (v=0) then frame_done_in -> write addr 1, data {Y6,Y7,0,0,0,0}; frame_done_out exactly 1 cycle after that wea_out.
5. DECIMATE=2, pixels (3,2) and (4,2) -> (3,2) dropped; (4,2) gives idx 162, word 27, lane 0. h=320 input -> no write, oor_out=1 and stays 1.
6. MODE=1, GREY_BITS=4, PIX_PER_WORD=1, pixel 16'h07E0 -> data_out=4'hF, addr=idx. Three default-mode pixels then rst_in -> no write; subsequent frame packs from an empty buffer.
